cov_accum: RTL and testbench
============================

Name: cov_accum

Overview:
- Upstream stage of the OBB eigen-solver.
- Consumes a stream of N signed 3-D points (x,y,z) and accumulates first- and second-order sums.
- Produces the six unique entries of the symmetric 3x3 covariance matrix as m1,m2,m3,m5,m6,m9 (row-major upper triangle: xx,xy,xz,yy,yz,zz).
- The iteration-0 input of the Jacobi matrix mux consumes these entries; cov_valid tells the controller the initial matrix is ready.

Parameters:
- DIN_W, 10, signed coordinate width.
- NLOG2, 3, log2 of points per batch (N = 2^NLOG2 = 8).
- OUT_W, 21, signed width of each covariance output.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that begins a new batch.
- pt_valid  in  1  point present on x/y/z.
- pt_ready  out  1  block can accept a point.
- x  in  DIN_W  signed x coordinate.
- y  in  DIN_W  signed y coordinate.
- z  in  DIN_W  signed z coordinate.
- busy  out  1  high in ACCUM or CALC.
- cov_valid  out  1  high while m outputs hold a completed result for the current batch.
- m1,m2,m3,m5,m6,m9  out  OUT_W each  signed covariance xx,xy,xz,yy,yz,zz.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; all sums, point counter and calc index = 0.
  - m* = 0; pt_ready=0, busy=0, cov_valid=0.
- FSM states and transitions:
  - IDLE -> ACCUM on start.
  - ACCUM -> CALC on the edge that accepts the N-th point.
  - CALC -> DONE after exactly 6 cycles.
  - DONE -> ACCUM on start.
  - start is ignored in ACCUM and CALC.
- Entering ACCUM (on the start edge):
  - Clear Sx,Sy,Sz,Sxx,Sxy,Sxz,Syy,Syz,Szz and the point counter.
  - Clear cov_valid; m* keep their old values.
- ACCUM:
  - pt_ready=1 (registered, asserted the cycle after start).
  - A point is accepted on any edge where pt_valid & pt_ready.
  - Each accepted point adds to all nine sums and increments the counter.
  - Cycles with pt_valid=0 change nothing.
  - pt_ready drops to 0 on the edge that accepts the N-th point; exactly N points are accepted per batch.
- Widths:
  - S1 sums are DIN_W+NLOG2 bits.
  - S2 sums are 2*DIN_W+NLOG2 bits.
  - The CALC datapath is 2*DIN_W+2*NLOG2+2 bits. No overflow is possible internally.
- CALC:
  - One shared multiplier, one entry per cycle, in order m1,m2,m3,m5,m6,m9.
  - Entry(a,b) = (N*Sab - Sa*Sb) >>> (2*NLOG2): arithmetic shift, i.e. floor division.
  - The result saturates to the signed OUT_W range; this cannot trigger at default parameters.
  - Each m register is written on its own CALC cycle.
- Timing:
  - Let edge k be the edge that accepts the last point.
  - m1 is written at edge k+1 and m9 at edge k+6.
  - cov_valid rises at edge k+6 and state becomes DONE.
- DONE:
  - cov_valid=1 and m* are held stable.
  - pt_ready=0, busy=0.
- Simultaneous pt_valid and start in DONE: the start edge accepts no point; pt_ready rises the following cycle.
- Reset mid-batch: immediate return to IDLE and all outputs zero; no partial result is ever flagged valid.

Test Plan:
1. Reset, start, 8 points all (5,5,5) with pt_valid continuous -> cov_valid at edge k+6; all six m = 0.
2. x = 0..7, y = z = 0 -> Sx=28, Sxx=140; m1 = (1120-784)>>>6 = 5; m2=m3=m5=m6=m9=0.
3. x = 0..7, y = -x, z = 0 -> m1=5, m5=5, m2 = -336>>>6 = -6 (floor check), others 0.
4. Backpressure: same stream as case 2 with pt_valid low on alternate cycles -> same results; pt_ready low after the 8th accept; no 9th point taken.
5. start pulsed mid-ACCUM after 3 points -> ignored, batch completes normally. Then start in DONE -> cov_valid drops next cycle, and m* keep old values until the new m1 write.
6. rst_n asserted asynchronously (mid-cycle) after 5 points -> outputs zero immediately. Release reset, then a full batch per case 2 -> m1=5.

Source files
------------

// File: rtl/cov_accum.sv
// cov_accum: accumulates first- and second-order sums over a batch of
// N = 2**NLOG2 signed 3-D points, then computes the six unique entries of the
// symmetric 3x3 covariance matrix with a single shared multiplier.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   start                 one-cycle pulse, begins a batch (IDLE/DONE only)
//   pt_valid / pt_ready   point handshake; x, y, z are signed coordinates
//   busy                  high in ACCUM or CALC
//   cov_valid             m outputs hold a completed result for this batch
//   m1,m2,m3,m5,m6,m9     covariance xx, xy, xz, yy, yz, zz (signed)
//
// state | meaning
// IDLE  | after reset, waiting for start
// ACCUM | accepting points, updating the nine sums
// CALC  | six cycles, one covariance entry per cycle
// DONE  | result valid and held, waiting for start
module cov_accum #(
    parameter int DIN_W = 10,
    parameter int NLOG2 = 3,
    parameter int OUT_W = 21
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    pt_valid,
    output logic                    pt_ready,
    input  logic signed [DIN_W-1:0] x,
    input  logic signed [DIN_W-1:0] y,
    input  logic signed [DIN_W-1:0] z,
    output logic                    busy,
    output logic                    cov_valid,
    output logic signed [OUT_W-1:0] m1,
    output logic signed [OUT_W-1:0] m2,
    output logic signed [OUT_W-1:0] m3,
    output logic signed [OUT_W-1:0] m5,
    output logic signed [OUT_W-1:0] m6,
    output logic signed [OUT_W-1:0] m9
);

    localparam int N   = 1 << NLOG2;
    localparam int S1W = DIN_W + NLOG2;
    localparam int S2W = 2 * DIN_W + NLOG2;
    localparam int PW  = 2 * DIN_W;
    localparam int CW  = 2 * DIN_W + 2 * NLOG2 + 2;
    localparam int HW  = CW - OUT_W + 1;
    localparam logic [NLOG2-1:0] CNT_LAST = NLOG2'(N - 1);
    localparam logic [2:0]       IDX_LAST = 3'd5;

    typedef enum logic [1:0] {IDLE, ACCUM, CALC, DONE} state_t;

    state_t state, state_nxt;

    logic [NLOG2-1:0] cnt;
    logic [2:0]       idx;

    logic signed [S1W-1:0] sx, sy, sz;
    logic signed [S2W-1:0] sxx, sxy, sxz, syy, syz, szz;

    logic accept, last_pt, start_batch, calc_last;

    assign accept      = pt_valid & pt_ready;
    assign last_pt     = accept && (cnt == CNT_LAST);
    assign start_batch = start && (state == IDLE || state == DONE);
    assign calc_last   = (state == CALC) && (idx == IDX_LAST);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        unique case (state)
            IDLE:  if (start) state_nxt = ACCUM;
            ACCUM: begin
                busy = 1'b1;
                if (last_pt) state_nxt = CALC;
            end
            CALC: begin
                busy = 1'b1;
                if (idx == IDX_LAST) state_nxt = DONE;
            end
            DONE:  if (start) state_nxt = ACCUM;
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------- point products
    logic signed [PW-1:0] xe, ye, ze;
    logic signed [PW-1:0] pxx, pxy, pxz, pyy, pyz, pzz;

    assign xe  = {{DIN_W{x[DIN_W-1]}}, x};
    assign ye  = {{DIN_W{y[DIN_W-1]}}, y};
    assign ze  = {{DIN_W{z[DIN_W-1]}}, z};
    assign pxx = xe * xe;
    assign pxy = xe * ye;
    assign pxz = xe * ze;
    assign pyy = ye * ye;
    assign pyz = ye * ze;
    assign pzz = ze * ze;

    // --------------------------------------------- shared CALC datapath
    logic signed [S2W-1:0]   sab;
    logic signed [S1W-1:0]   sa, sb;
    logic signed [2*S1W-1:0] sa_w, sb_w, prod;
    logic signed [CW-1:0]    nsab, prod_ext, diff, shifted;
    logic        [HW-1:0]    hi;
    logic signed [OUT_W-1:0] sat;

    always_comb begin
        sab = sxx;
        sa  = sx;
        sb  = sx;
        unique case (idx)
            3'd1:    begin sab = sxy; sa = sx; sb = sy; end
            3'd2:    begin sab = sxz; sa = sx; sb = sz; end
            3'd3:    begin sab = syy; sa = sy; sb = sy; end
            3'd4:    begin sab = syz; sa = sy; sb = sz; end
            3'd5:    begin sab = szz; sa = sz; sb = sz; end
            default: begin sab = sxx; sa = sx; sb = sx; end
        endcase
    end

    assign sa_w     = {{S1W{sa[S1W-1]}}, sa};
    assign sb_w     = {{S1W{sb[S1W-1]}}, sb};
    assign prod     = sa_w * sb_w;
    // N*Sab is a left shift by NLOG2
    assign nsab     = {{(CW-S2W-NLOG2){sab[S2W-1]}}, sab, {NLOG2{1'b0}}};
    assign prod_ext = {{(CW-2*S1W){prod[2*S1W-1]}}, prod};
    assign diff     = nsab - prod_ext;
    // arithmetic shift floors toward minus infinity
    assign shifted  = diff >>> (2 * NLOG2);
    assign hi       = shifted[CW-1:OUT_W-1];

    always_comb begin
        if ((&hi) || !(|hi)) sat = shifted[OUT_W-1:0];
        else if (shifted[CW-1]) sat = {1'b1, {(OUT_W-1){1'b0}}};
        else                    sat = {1'b0, {(OUT_W-1){1'b1}}};
    end

    // --------------------------------------------------- sums and outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            idx       <= '0;
            pt_ready  <= 1'b0;
            cov_valid <= 1'b0;
            sx  <= '0; sy  <= '0; sz  <= '0;
            sxx <= '0; sxy <= '0; sxz <= '0;
            syy <= '0; syz <= '0; szz <= '0;
            m1  <= '0; m2  <= '0; m3  <= '0;
            m5  <= '0; m6  <= '0; m9  <= '0;
        end else if (start_batch) begin
            cnt       <= '0;
            idx       <= '0;
            pt_ready  <= 1'b1;
            cov_valid <= 1'b0;
            sx  <= '0; sy  <= '0; sz  <= '0;
            sxx <= '0; sxy <= '0; sxz <= '0;
            syy <= '0; syz <= '0; szz <= '0;
        end else if (state == ACCUM) begin
            if (accept) begin
                sx  <= sx + {{NLOG2{x[DIN_W-1]}}, x};
                sy  <= sy + {{NLOG2{y[DIN_W-1]}}, y};
                sz  <= sz + {{NLOG2{z[DIN_W-1]}}, z};
                sxx <= sxx + {{NLOG2{pxx[PW-1]}}, pxx};
                sxy <= sxy + {{NLOG2{pxy[PW-1]}}, pxy};
                sxz <= sxz + {{NLOG2{pxz[PW-1]}}, pxz};
                syy <= syy + {{NLOG2{pyy[PW-1]}}, pyy};
                syz <= syz + {{NLOG2{pyz[PW-1]}}, pyz};
                szz <= szz + {{NLOG2{pzz[PW-1]}}, pzz};
                cnt <= cnt + 1'b1;
                if (last_pt) begin
                    pt_ready <= 1'b0;
                    idx      <= '0;
                end
            end
        end else if (state == CALC) begin
            unique case (idx)
                3'd0:    m1 <= sat;
                3'd1:    m2 <= sat;
                3'd2:    m3 <= sat;
                3'd3:    m5 <= sat;
                3'd4:    m6 <= sat;
                default: m9 <= sat;
            endcase
            idx <= idx + 1'b1;
            if (calc_last) cov_valid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cov_accum.sv
// Directed testbench for cov_accum with hand-computed covariance results.
module tb_cov_accum;

    localparam int DIN_W = 10;
    localparam int NLOG2 = 3;
    localparam int OUT_W = 21;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic pt_valid = 1'b0;
    logic pt_ready;
    logic signed [DIN_W-1:0] x = '0, y = '0, z = '0;
    logic busy, cov_valid;
    logic signed [OUT_W-1:0] m1, m2, m3, m5, m6, m9;

    cov_accum #(.DIN_W(DIN_W), .NLOG2(NLOG2), .OUT_W(OUT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .pt_valid(pt_valid),
        .pt_ready(pt_ready), .x(x), .y(y), .z(z), .busy(busy),
        .cov_valid(cov_valid), .m1(m1), .m2(m2), .m3(m3), .m5(m5),
        .m6(m6), .m9(m9)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int px[8];
    int py[8];
    int pz[8];
    int ex[6];

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_m1"}, m1, 0);
        chk({tag, "_m2"}, m2, 0);
        chk({tag, "_m3"}, m3, 0);
        chk({tag, "_m5"}, m5, 0);
        chk({tag, "_m6"}, m6, 0);
        chk({tag, "_m9"}, m9, 0);
        chk({tag, "_pt_ready"}, {31'd0, pt_ready}, 0);
        chk({tag, "_busy"}, {31'd0, busy}, 0);
        chk({tag, "_cov_valid"}, {31'd0, cov_valid}, 0);
    endtask

    task automatic set_pts(input int kind);
        for (int i = 0; i < 8; i++) begin
            px[i] = 0; py[i] = 0; pz[i] = 0;
            case (kind)
                0: begin px[i] = 5; py[i] = 5; pz[i] = 5; end
                1: px[i] = i;
                2: begin px[i] = i; py[i] = -i; end
                default: if (i == 0) begin px[i] = -512; py[i] = 511; pz[i] = -512; end
            endcase
        end
    endtask

    task automatic set_exp(input int a, input int b, input int c,
                           input int d, input int e, input int f);
        ex[0] = a; ex[1] = b; ex[2] = c; ex[3] = d; ex[4] = e; ex[5] = f;
    endtask

    // start from IDLE/DONE; called at posedge+1
    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("start_pt_ready", {31'd0, pt_ready}, 1);
        chk("start_cov_valid_clr", {31'd0, cov_valid}, 0);
    endtask

    // feeds npts points; returns at edge-of-last-accept + 1
    task automatic feed(input string tag, input bit gaps, input int start_at,
                        input int npts);
        int acc = 0;
        int cyc = 0;
        bit took;
        while (acc < npts && cyc < 200) begin
            pt_valid = gaps ? (cyc % 2 == 0) : 1'b1;
            x = DIN_W'(px[acc]);
            y = DIN_W'(py[acc]);
            z = DIN_W'(pz[acc]);
            start = (acc == start_at);
            took = pt_valid && pt_ready;
            @(posedge clk); #1;
            if (took) acc++;
            cyc++;
        end
        start = 1'b0;
        // junk held valid: must not be taken as a ninth point
        pt_valid = 1'b1;
        x = 10'sd300; y = -10'sd300; z = 10'sd77;
        chk({tag, "_accepted"}, acc, npts);
        if (npts == 8) chk({tag, "_pt_ready_drop"}, {31'd0, pt_ready}, 0);
    endtask

    task automatic calc_check(input string tag);
        for (int e = 1; e <= 6; e++) begin
            @(posedge clk); #1;
            if (e == 1) chk({tag, "_m1_at_k1"}, m1, ex[0]);
            if (e < 6) chk({tag, "_cov_valid_early"}, {31'd0, cov_valid}, 0);
            else       chk({tag, "_cov_valid_k6"}, {31'd0, cov_valid}, 1);
        end
        chk({tag, "_busy_done"}, {31'd0, busy}, 0);
        chk({tag, "_pt_ready_done"}, {31'd0, pt_ready}, 0);
        chk({tag, "_m1"}, m1, ex[0]);
        chk({tag, "_m2"}, m2, ex[1]);
        chk({tag, "_m3"}, m3, ex[2]);
        chk({tag, "_m5"}, m5, ex[3]);
        chk({tag, "_m6"}, m6, ex[4]);
        chk({tag, "_m9"}, m9, ex[5]);
        repeat (3) @(posedge clk);
        #1;
        chk({tag, "_hold_valid"}, {31'd0, cov_valid}, 1);
        chk({tag, "_hold_m9"}, m9, ex[5]);
        pt_valid = 1'b0;
    endtask

    initial begin
        #12;
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: constant points -> zero covariance
        set_pts(0); set_exp(0, 0, 0, 0, 0, 0);
        do_start();
        chk("accum_busy", {31'd0, busy}, 1);
        feed("c1", 1'b0, -1, 8);
        calc_check("c1");

        // 2: x ramp
        set_pts(1); set_exp(5, 0, 0, 0, 0, 0);
        do_start();
        feed("c2", 1'b0, -1, 8);
        calc_check("c2");

        // 3: y = -x, floor on negative
        set_pts(2); set_exp(5, -6, 0, 5, 0, -0);
        do_start();
        feed("c3", 1'b0, -1, 8);
        calc_check("c3");

        // extreme coordinates in one point
        set_pts(3); set_exp(28672, -28616, 28672, 28560, -28616, 28672);
        do_start();
        feed("ext", 1'b0, -1, 8);
        calc_check("ext");

        // 4: backpressure
        set_pts(1); set_exp(5, 0, 0, 0, 0, 0);
        do_start();
        feed("c4", 1'b1, -1, 8);
        calc_check("c4");

        // 5: start mid-ACCUM ignored
        set_pts(1); set_exp(5, 0, 0, 0, 0, 0);
        do_start();
        feed("c5", 1'b0, 3, 8);
        calc_check("c5");

        // start in DONE with a point offered on the same edge
        set_pts(3); set_exp(28672, -28616, 28672, 28560, -28616, 28672);
        pt_valid = 1'b1; x = 10'sd100; y = 10'sd100; z = 10'sd100;
        do_start();
        chk("c5_m1_kept", m1, 5);
        feed("c5b", 1'b0, -1, 8);
        chk("c5b_m1_before_write", m1, 5);
        calc_check("c5b");

        // 6: async reset after 5 points
        set_pts(1);
        do_start();
        feed("c6", 1'b0, -1, 5);
        #3;
        rst_n = 1'b0;
        #1;
        chk_all_zero("c6_rst");
        pt_valid = 1'b0;
        #3;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("c6_idle_valid", {31'd0, cov_valid}, 0);
        chk("c6_idle_busy", {31'd0, busy}, 0);
        set_exp(5, 0, 0, 0, 0, 0);
        do_start();
        feed("c6b", 1'b0, -1, 8);
        calc_check("c6b");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
